// File: rtl/sodor5_mem_pkg.sv
// Shared types and constants for the sodor5 unified-memory arbiter.
package sodor5_mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STAT_W = 16;
    localparam int unsigned LAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } mem_arb_state_t;

    // Wrap-around increment for the statistics counters.
    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
        return v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/sodor5_lat_timer.sv
// Memory latency counter: load to 1 on issue, count up while busy, flag target.
module sodor5_lat_timer
    import sodor5_mem_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             inc,
    input  logic [LAT_W-1:0] target,
    output logic [LAT_W-1:0] cnt,
    output logic             done
);

    // Counter register; load has priority over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LAT_W'(1);
        end else if (inc) begin
            cnt <= cnt + LAT_W'(1);
        end
    end

    assign done = (cnt == target);

endmodule

// File: rtl/sodor5_mem_arbiter.sv
// Arbitrates one single-ported fixed-latency memory between fetch and data ports.
module sodor5_mem_arbiter #(
    parameter int unsigned ADDR_W     = sodor5_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W     = sodor5_mem_pkg::DATA_W,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,

    input  logic                              imem_req_valid,
    input  logic [ADDR_W-1:0]                 imem_req_addr,
    output logic                              imem_req_ready,
    output logic                              imem_resp_valid,
    output logic [DATA_W-1:0]                 imem_resp_data,

    input  logic                              dmem_req_valid,
    input  logic [ADDR_W-1:0]                 dmem_req_addr,
    input  logic                              dmem_req_wen,
    input  logic [DATA_W-1:0]                 dmem_req_wdata,
    output logic                              dmem_req_ready,
    output logic                              dmem_resp_valid,
    output logic [DATA_W-1:0]                 dmem_resp_data,

    output logic                              mem_req_valid,
    output logic [ADDR_W-1:0]                 mem_req_addr,
    output logic                              mem_req_wen,
    output logic [DATA_W-1:0]                 mem_req_wdata,
    input  logic [DATA_W-1:0]                 mem_resp_data,

    output logic                              control_fetch_o,
    output logic [sodor5_mem_pkg::STAT_W-1:0] imem_grant_cnt,
    output logic [sodor5_mem_pkg::STAT_W-1:0] dmem_grant_cnt,
    output logic [sodor5_mem_pkg::STAT_W-1:0] conflict_cnt
);

    import sodor5_mem_pkg::*;

    localparam logic [LAT_W-1:0] LAT_TGT    = LAT_W'(MEM_LAT);
    localparam logic [LAT_W-1:0] STARVE_LIM = LAT_W'(STARVE_MAX);

    mem_arb_state_t    state_q;
    mem_arb_state_t    state_d;
    logic              grant_i;
    logic              grant_d;
    logic [LAT_W-1:0]  lat_cnt;
    logic              lat_done;
    logic [LAT_W-1:0]  starve_cnt;
    logic [STAT_W-1:0] imem_grant_q;
    logic [STAT_W-1:0] dmem_grant_q;
    logic [STAT_W-1:0] conflict_q;

    // Latency timer for the single outstanding transaction.
    sodor5_lat_timer u_lat_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (grant_i | grant_d),
        .inc     (state_q != IDLE),
        .target  (LAT_TGT),
        .cnt     (lat_cnt),
        .done    (lat_done)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration, memory request steering, response pulses and next state.
    always_comb begin
        state_d         = state_q;
        grant_i         = 1'b0;
        grant_d         = 1'b0;
        imem_req_ready  = 1'b0;
        dmem_req_ready  = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_addr    = '0;
        mem_req_wen     = 1'b0;
        mem_req_wdata   = '0;
        imem_resp_valid = 1'b0;
        dmem_resp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Data wins a tie unless fetch has waited the maximum run.
                if (imem_req_valid && (!dmem_req_valid || (starve_cnt == STARVE_LIM))) begin
                    grant_i        = 1'b1;
                    imem_req_ready = 1'b1;
                    mem_req_valid  = 1'b1;
                    mem_req_addr   = imem_req_addr;
                    state_d        = BUSY_I;
                end else if (dmem_req_valid) begin
                    grant_d        = 1'b1;
                    dmem_req_ready = 1'b1;
                    mem_req_valid  = 1'b1;
                    mem_req_addr   = dmem_req_addr;
                    mem_req_wen    = dmem_req_wen;
                    mem_req_wdata  = dmem_req_wdata;
                    state_d        = BUSY_D;
                end
            end
            BUSY_I: begin
                if (lat_done) begin
                    imem_resp_valid = 1'b1;
                    state_d         = IDLE;
                end
            end
            BUSY_D: begin
                if (lat_done) begin
                    dmem_resp_valid = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_resp_data  = mem_resp_data;
    assign dmem_resp_data  = mem_resp_data;
    assign control_fetch_o = imem_resp_valid;

    // Starvation guard: count data grants taken while fetch was waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!imem_req_valid) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + LAT_W'(1);
            end
        end
    end

    // Wrap-around grant and conflict statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem_grant_q <= '0;
            dmem_grant_q <= '0;
            conflict_q   <= '0;
        end else begin
            if (grant_i) begin
                imem_grant_q <= stat_inc(imem_grant_q);
            end
            if (grant_d) begin
                dmem_grant_q <= stat_inc(dmem_grant_q);
            end
            if ((state_q == IDLE) && imem_req_valid && dmem_req_valid) begin
                conflict_q <= stat_inc(conflict_q);
            end
        end
    end

    assign imem_grant_cnt = imem_grant_q;
    assign dmem_grant_cnt = dmem_grant_q;
    assign conflict_cnt   = conflict_q;

endmodule
